// File: rtl/saida_bcd.sv
// Narrows a signed 32-bit value to sign + DIGITS saturated BCD digits for the display,
// using iterative shift-and-add-3 (one bit per cycle) behind a start/done handshake.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for start; results from the last conversion are held
// S_CONV | 32 shift-and-add-3 iterations, count tracks iteration index
// S_DONE | accumulator complete; results registered, done pulses next
module saida_bcd #(
   parameter int DIGITS = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [31:0]           valor,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  negativo,
   output logic                  overflow,
   output logic [DIGITS-1:0]     digit_en
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CONV,
      S_DONE
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [31:0]         mag;
   logic [39:0]         acc;
   logic [4:0]          count;
   logic                sign;

   logic [39:0]         acc_adj;
   logic                ovf_nxt;
   logic [4*DIGITS-1:0] bcd_nxt;
   logic [DIGITS-1:0]   en_nxt;
   logic                neg_nxt;
   logic                any_nz;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_CONV;
         S_CONV:  if (count == 5'd31) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   assign busy = (state != S_IDLE);

   // Add-3 correction applied to every nibble before the shift.
   always_comb begin
      acc_adj = '0;
      for (int i = 0; i < 10; i++) begin
         if (acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = 4'(acc[4*i +: 4] + 4'd3);
         else                       acc_adj[4*i +: 4] = acc[4*i +: 4];
      end
   end

   always_comb begin
      ovf_nxt = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (i >= DIGITS && acc[4*i +: 4] != 4'd0) ovf_nxt = 1'b1;
      end
      bcd_nxt = '0;
      for (int i = 0; i < DIGITS; i++) begin
         bcd_nxt[4*i +: 4] = ovf_nxt ? 4'd9 : acc[4*i +: 4];
      end
      // A digit is lit if it or any more-significant digit is nonzero; digit 0 always lit.
      any_nz = 1'b0;
      en_nxt = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         any_nz    = any_nz | (bcd_nxt[4*i +: 4] != 4'd0);
         en_nxt[i] = any_nz | (i == 0);
      end
      neg_nxt = sign & (|bcd_nxt);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mag      <= '0;
         acc      <= '0;
         count    <= '0;
         sign     <= 1'b0;
         done     <= 1'b0;
         bcd      <= '0;
         negativo <= 1'b0;
         overflow <= 1'b0;
         digit_en <= DIGITS'(1);
      end else begin
         done <= (state == S_DONE);
         case (state)
            S_IDLE: begin
               if (start) begin
                  sign  <= valor[31];
                  mag   <= valor[31] ? (~valor + 32'd1) : valor;
                  acc   <= '0;
                  count <= '0;
               end
            end
            S_CONV: begin
               acc   <= {acc_adj[38:0], mag[31]};
               mag   <= {mag[30:0], 1'b0};
               count <= count + 5'd1;
            end
            S_DONE: begin
               bcd      <= bcd_nxt;
               negativo <= neg_nxt;
               overflow <= ovf_nxt;
               digit_en <= en_nxt;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_saida_bcd.sv
// Scoreboard bench for saida_bcd: directed values with hand-computed BCD results,
// handshake corner cases, back-to-back conversions and mid-conversion reset.
module tb_saida_bcd;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [31:0] valor;
   logic        busy;
   logic        done;
   logic [31:0] bcd;
   logic        negativo;
   logic        overflow;
   logic [7:0]  digit_en;

   saida_bcd #(.DIGITS(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .valor    (valor),
      .busy     (busy),
      .done     (done),
      .bcd      (bcd),
      .negativo (negativo),
      .overflow (overflow),
      .digit_en (digit_en)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] bcd;
      logic        neg;
      logic        ov;
      logic [7:0]  en;
      int          scyc;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   logic [42:0] snap;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: pops one expectation per done pulse; between pulses results must hold.
   always @(negedge clk) begin
      if (rst_n) begin
         if (done) begin
            if (q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_done: got done=1 at cycle %0d, required no pulse", cyc);
            end else begin
               exp_t e;
               e = q.pop_front();
               checks++;
               if (bcd !== e.bcd || negativo !== e.neg || overflow !== e.ov || digit_en !== e.en) begin
                  errors++;
                  $display("FAIL result: got bcd=%h neg=%b ov=%b en=%b, required bcd=%h neg=%b ov=%b en=%b",
                           bcd, negativo, overflow, digit_en, e.bcd, e.neg, e.ov, e.en);
               end
               checks++;
               if (cyc - e.scyc != 34) begin
                  errors++;
                  $display("FAIL latency: got %0d cycles, required 34", cyc - e.scyc);
               end
            end
         end else begin
            checks++;
            if ({bcd, negativo, overflow, digit_en} !== snap) begin
               errors++;
               $display("FAIL hold: outputs changed without done, got %h, required %h",
                        {bcd, negativo, overflow, digit_en}, snap);
            end
         end
      end
      snap = {bcd, negativo, overflow, digit_en};
   end

   task automatic push(input logic [31:0] b, input logic n, input logic o, input logic [7:0] en, input int s);
      exp_t e;
      e.bcd = b; e.neg = n; e.ov = o; e.en = en; e.scyc = s;
      q.push_back(e);
   endtask

   task automatic issue(input logic [31:0] v, input logic [31:0] b, input logic n,
                        input logic o, input logic [7:0] en);
      @(negedge clk);
      valor = v;
      start = 1'b1;
      push(b, n, o, en, cyc);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done();
      bit seen = 1'b0;
      for (int n = 0; n < 200 && !seen; n++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      if (!seen) begin
         checks++; errors++;
         $display("FAIL timeout: got no done within 200 cycles, required a done pulse");
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || bcd !== 32'h0 || negativo !== 1'b0 ||
          overflow !== 1'b0 || digit_en !== 8'b0000_0001) begin
         errors++;
         $display("FAIL %s: got busy=%b done=%b bcd=%h neg=%b ov=%b en=%b, required 0 0 00000000 0 0 00000001",
                  tag, busy, done, bcd, negativo, overflow, digit_en);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      valor = '0;
      #22;
      check_reset_outputs("reset_state");
      @(negedge clk);
      #2 rst_n = 1'b1;

      issue(32'd0,         32'h0000_0000, 1'b0, 1'b0, 8'b0000_0001); wait_done();
      issue(32'd12345,     32'h0001_2345, 1'b0, 1'b0, 8'b0001_1111); wait_done();
      issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 8'b0000_0001); wait_done();
      issue(-32'sd1000,    32'h0000_1000, 1'b1, 1'b0, 8'b0000_1111); wait_done();
      issue(32'd99999999,  32'h9999_9999, 1'b0, 1'b0, 8'hFF);        wait_done();
      issue(32'd100000000, 32'h9999_9999, 1'b0, 1'b1, 8'hFF);        wait_done();
      issue(32'h8000_0000, 32'h9999_9999, 1'b1, 1'b1, 8'hFF);        wait_done();

      // start during CONV must be ignored; busy must stay high for all 32 iterations
      issue(32'd42, 32'h0000_0042, 1'b0, 1'b0, 8'b0000_0011);
      for (int k = 0; k < 32; k++) begin
         checks++;
         if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_conv: got busy=%b at iteration %0d, required 1", busy, k);
         end
         if (k == 5) begin valor = 32'd7; start = 1'b1; end
         if (k == 6) start = 1'b0;
         @(negedge clk);
      end
      wait_done();

      // start held high: accepted again in each done cycle, 34 cycles apart
      @(negedge clk);
      valor = 32'd123;
      start = 1'b1;
      push(32'h0000_0123, 1'b0, 1'b0, 8'b0000_0111, cyc);
      push(32'h0000_0123, 1'b0, 1'b0, 8'b0000_0111, cyc + 34);
      push(32'h0000_0123, 1'b0, 1'b0, 8'b0000_0111, cyc + 68);
      wait_done();
      wait_done();
      wait_done();
      start = 1'b0;

      // reset during conversion of 555: no done, outputs back to reset values
      @(negedge clk);
      valor = 32'd555;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("reset_mid_conv");
      @(negedge clk);
      @(negedge clk);
      check_reset_outputs("reset_held");
      #2 rst_n = 1'b1;
      repeat (40) @(negedge clk);

      issue(32'd555, 32'h0000_0555, 1'b0, 1'b0, 8'b0000_0111); wait_done();

      repeat (40) @(negedge clk);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL pending: got %0d expectations unconsumed, required 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/saida_bcd.md
Name: saida_bcd

Overview:
Output-side counterpart of the immediate/input sign-extension path. It takes a 32-bit two's-complement register value bound for the board display and narrows it to a sign flag plus DIGITS decimal BCD digits, with saturation and leading-zero blanking. Conversion is iterative (shift-and-add-3, one bit per cycle) and uses a start/done handshake. It sits between the processor's output instruction write port and the seven-segment driver.

Parameters:
DIGITS, 8, number of BCD digits presented; legal range 1..10.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request conversion of valor; sampled only in IDLE.
valor  input  32  signed two's-complement value to display.
busy  output  1  high whenever state is not IDLE.
done  output  1  one-cycle pulse when new results are valid.
bcd  output  4*DIGITS  result digits; digit i in bits [4i+3:4i], digit 0 is least significant.
negativo  output  1  sign of the last converted value (1 = negative).
overflow  output  1  magnitude exceeded 10^DIGITS-1 and bcd is saturated.
digit_en  output  DIGITS  per-digit display enable for leading-zero blanking.

Behaviour:
- Reset (asynchronous, rst_n low): state=IDLE; busy=0, done=0, bcd=0, negativo=0, overflow=0, digit_en = only bit 0 set. Internal shift, BCD and count registers are cleared.
- States: IDLE, CONV, DONE.
- IDLE, with start=1 on an edge:
  - capture sign = valor[31];
  - capture magnitude mag = valor[31] ? (~valor + 1) : valor, as 32-bit unsigned. -2^31 gives 0x8000_0000 with no overflow;
  - clear the internal 40-bit (10-digit) BCD accumulator;
  - set count=0 and go to CONV.
- IDLE with start=0: stay in IDLE; outputs hold.
- CONV, one iteration per cycle:
  - each 4-bit accumulator nibble >= 5 gets +3;
  - then shift {acc, mag} left by 1, so the mag MSB enters the acc LSB;
  - count increments;
  - after the iteration with count==31 (32 iterations in total), go to DONE.
- DONE, single cycle. Registered results become visible the cycle after, together with done=1:
  - overflow = any accumulator digit at index >= DIGITS is nonzero;
  - bcd = overflow ? all digits 9 : accumulator digits [DIGITS-1:0];
  - negativo = captured sign. A zero result always gives negativo=0;
  - digit_en[i] = 1 if i==0, or if any digit j>=i of the presented bcd is nonzero. All ones when saturated;
  - return to IDLE.
- done is high exactly one cycle. It asserts in the first IDLE cycle after DONE, so start accepted at edge T gives done=1 during cycle T+34.
- busy=1 from the cycle after start is accepted until DONE completes, inclusive.
- bcd, negativo, overflow and digit_en change only when done asserts. They hold across later conversions until the next done.
- start while busy (CONV or DONE) is ignored; no queuing. start coincident with done (first IDLE cycle) is accepted.
- valor is sampled only at the accepting edge; later changes do not affect the conversion in progress.
- Reset mid-conversion aborts the conversion: no done pulse, outputs return to reset values.

Test Plan:
- valor=0, start pulse -> done 34 cycles later; bcd=0x00000000, negativo=0, overflow=0, digit_en=8'b00000001.
- valor=12345 -> bcd=0x00012345, negativo=0, digit_en=8'b00011111.
- valor=-1 (0xFFFFFFFF) -> bcd=0x00000001, negativo=1, overflow=0, digit_en=8'b00000001.
- Saturation boundary:
  - valor=99999999 -> bcd=0x99999999, overflow=0;
  - valor=100000000 -> bcd=0x99999999, overflow=1;
  - valor=-2147483648 -> bcd=0x99999999, negativo=1, overflow=1, digit_en=8'hFF.
- Handshake:
  - start 42, then start 7 at cycle 5 of CONV -> only one done, result 0x00000042; busy stays high throughout;
  - start held high continuously -> back-to-back conversions with done every 34 cycles.
- Reset:
  - rst_n low at CONV iteration 10 of valor=555 -> no done pulse, all outputs at reset values;
  - after release, start 555 -> bcd=0x00000555.
